// File: rtl/fifo_tx_arbiter.sv
// Round-robin drain of two byte FIFOs into a byte transmitter, framing each
// burst with a header byte {10,ch,00000} and a trailer byte {11,ch,count-1}.
module fifo_tx_arbiter #(
   parameter int unsigned BURST_MAX = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       a_rd_en,
   input  logic [7:0] a_rd_DATA,
   input  logic       a_rd_empty,
   output logic       b_rd_en,
   input  logic [7:0] b_rd_DATA,
   input  logic       b_rd_empty,
   output logic       tx_start,
   output logic [7:0] tx_DATA,
   input  logic       tx_busy,
   output logic       busy,
   output logic [1:0] grant
);

   localparam logic [5:0] BMAX = 6'(BURST_MAX);

   typedef enum logic [2:0] {IDLE, HDR, RD, LAT, SEND, TRL, TXW} state_e;

   state_e     state_q, state_d;
   state_e     ret_q, ret_d;
   logic       ch_q, ch_d;
   logic       last_q, last_d;
   logic       guard_q, guard_d;
   logic [5:0] cnt_q, cnt_d;
   logic       a_rd_en_q, a_rd_en_d;
   logic       b_rd_en_q, b_rd_en_d;
   logic       tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       busy_q, busy_d;
   logic [1:0] grant_q, grant_d;

   logic       sel_empty;
   logic [7:0] sel_data;
   logic [4:0] trl_cnt;

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      ch_d       = ch_q;
      last_d     = last_q;
      guard_d    = guard_q;
      cnt_d      = cnt_q;
      a_rd_en_d  = 1'b0;
      b_rd_en_d  = 1'b0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      sel_empty  = ch_q ? b_rd_empty : a_rd_empty;
      sel_data   = ch_q ? b_rd_DATA  : a_rd_DATA;
      trl_cnt    = cnt_q[4:0] - 5'd1;

      case (state_q)
         IDLE: begin
            if (en && (!a_rd_empty || !b_rd_empty)) begin
               if (!a_rd_empty && !b_rd_empty) ch_d = ~last_q;
               else                            ch_d = a_rd_empty;
               cnt_d   = '0;
               state_d = HDR;
            end
         end
         HDR: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = {2'b10, ch_q, 5'b00000};
               guard_d    = 1'b1;
               ret_d      = RD;
               state_d    = TXW;
            end
         end
         RD: begin
            if (sel_empty || cnt_q == BMAX) begin
               state_d = TRL;
            end else begin
               a_rd_en_d = ~ch_q;
               b_rd_en_d = ch_q;
               cnt_d     = cnt_q + 6'd1;
               state_d   = LAT;
            end
         end
         LAT: begin
            // rd_en is registered, so the FIFO data lands one cycle after it is seen
            if (!(a_rd_en_q || b_rd_en_q)) begin
               tx_data_d = sel_data;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               guard_d    = 1'b1;
               ret_d      = RD;
               state_d    = TXW;
            end
         end
         TRL: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = {2'b11, ch_q, trl_cnt};
               last_d     = ch_q;
               cnt_d      = '0;
               guard_d    = 1'b1;
               ret_d      = IDLE;
               state_d    = TXW;
            end
         end
         TXW: begin
            // tx_busy is ignored in the tx_start cycle and the guard cycle after it
            if (tx_start_q) begin
               guard_d = 1'b1;
            end else if (guard_q) begin
               guard_d = 1'b0;
            end else if (!tx_busy) begin
               state_d = ret_q;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      grant_d = (state_d == IDLE) ? 2'b00 : {ch_d, ~ch_d};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         ret_q      <= IDLE;
         ch_q       <= 1'b0;
         last_q     <= 1'b1;
         guard_q    <= 1'b0;
         cnt_q      <= '0;
         a_rd_en_q  <= 1'b0;
         b_rd_en_q  <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         busy_q     <= 1'b0;
         grant_q    <= '0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         ch_q       <= ch_d;
         last_q     <= last_d;
         guard_q    <= guard_d;
         cnt_q      <= cnt_d;
         a_rd_en_q  <= a_rd_en_d;
         b_rd_en_q  <= b_rd_en_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
      end
   end

   assign a_rd_en  = a_rd_en_q;
   assign b_rd_en  = b_rd_en_q;
   assign tx_start = tx_start_q;
   assign tx_DATA  = tx_data_q;
   assign busy     = busy_q;
   assign grant    = grant_q;

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Scoreboard bench: a burst-level model predicts the transmitted byte stream
// from the FIFO contents; a monitor compares every tx_start against it.
module tb_fifo_tx_arbiter;

   localparam int unsigned BM = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic       a_rd_en, b_rd_en;
   logic [7:0] a_rd_DATA = 8'h00;
   logic [7:0] b_rd_DATA = 8'h00;
   logic       a_rd_empty = 1'b1;
   logic       b_rd_empty = 1'b1;
   logic       tx_start;
   logic [7:0] tx_DATA;
   logic       tx_busy;
   logic       busy;
   logic [1:0] grant;

   always #5 clk = ~clk;

   fifo_tx_arbiter #(.BURST_MAX(BM)) dut (
      .clk(clk), .rst(rst), .en(en),
      .a_rd_en(a_rd_en), .a_rd_DATA(a_rd_DATA), .a_rd_empty(a_rd_empty),
      .b_rd_en(b_rd_en), .b_rd_DATA(b_rd_DATA), .b_rd_empty(b_rd_empty),
      .tx_start(tx_start), .tx_DATA(tx_DATA), .tx_busy(tx_busy),
      .busy(busy), .grant(grant)
   );

   typedef struct {
      logic [7:0] d;
      logic       ch;
   } exp_t;

   int         tests = 0;
   int         fails = 0;
   exp_t       expq[$];
   exp_t       mon_e;
   logic [7:0] ma[$];
   logic [7:0] mb[$];
   logic       last_m = 1'b1;
   int         tx_seen = 0;
   int         a_pulses = 0;
   int         b_pulses = 0;

   // FIFO models: storage written by stimulus, read pointer owned by the FIFO
   logic [7:0] mem_a[1024];
   logic [7:0] mem_b[1024];
   int         wr_a = 0, wr_b = 0, rd_a = 0, rd_b = 0;

   always @(posedge clk) begin
      if (a_rd_en) begin
         a_rd_DATA <= mem_a[rd_a % 1024];
         rd_a = rd_a + 1;
      end
      if (b_rd_en) begin
         b_rd_DATA <= mem_b[rd_b % 1024];
         rd_b = rd_b + 1;
      end
      a_rd_empty <= (rd_a == wr_a);
      b_rd_empty <= (rd_b == wr_b);
   end

   // Transmitter: busy for 10 cycles starting the cycle after tx_start
   int   busy_cnt = 0;
   logic hold = 1'b0;
   assign tx_busy = (busy_cnt != 0) || hold;

   always @(posedge clk) begin
      if (tx_start)          busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic chk(input string name, input int got, input int exp_v);
      tests++;
      if (got != exp_v) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp_v, $time);
      end
   endtask

   task automatic load(input logic ch, input logic [7:0] d);
      if (!ch) begin
         mem_a[wr_a % 1024] = d;
         wr_a++;
         ma.push_back(d);
      end else begin
         mem_b[wr_b % 1024] = d;
         wr_b++;
         mb.push_back(d);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic ch);
      exp_t e;
      e.d  = d;
      e.ch = ch;
      expq.push_back(e);
   endtask

   task automatic predict_burst();
      logic       ch;
      int         n;
      int         avail;
      logic [7:0] d;
      if (ma.size() == 0 && mb.size() == 0) return;
      if (ma.size() != 0 && mb.size() != 0) ch = ~last_m;
      else                                  ch = (ma.size() == 0);
      push_exp({2'b10, ch, 5'b00000}, ch);
      n = 0;
      avail = ch ? mb.size() : ma.size();
      while (n < int'(BM) && avail > 0) begin
         if (ch) d = mb.pop_front();
         else    d = ma.pop_front();
         push_exp(d, ch);
         n++;
         avail--;
      end
      push_exp({2'b11, ch, 5'(n - 1)}, ch);
      last_m = ch;
   endtask

   task automatic predict_all();
      while (ma.size() + mb.size() > 0) predict_burst();
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (k < 3000 && !(expq.size() == 0 && busy == 1'b0 && tx_busy == 1'b0)) begin
         @(negedge clk);
         k++;
      end
      chk(name, int'(k < 3000), 1);
   endtask

   task automatic wait_tx(input int target, input string name);
      int k;
      k = 0;
      while (k < 2000 && tx_seen < target) begin
         @(negedge clk);
         k++;
      end
      chk(name, int'(tx_seen >= target), 1);
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_tx_start"}, int'(tx_start), 0);
      chk({pfx, "_tx_data"},  int'(tx_DATA),  0);
      chk({pfx, "_a_rd_en"},  int'(a_rd_en),  0);
      chk({pfx, "_b_rd_en"},  int'(b_rd_en),  0);
      chk({pfx, "_busy"},     int'(busy),     0);
      chk({pfx, "_grant"},    int'(grant),    0);
   endtask

   // Pulse reset between clock edges and resync the model to what is left in the FIFOs
   task automatic do_reset(input string pfx);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_reset(pfx);
      expq.delete();
      last_m = 1'b1;
      ma.delete();
      mb.delete();
      for (int i = rd_a; i < wr_a; i++) ma.push_back(mem_a[i % 1024]);
      for (int i = rd_b; i < wr_b; i++) mb.push_back(mem_b[i % 1024]);
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int base, a0, r0, t0, la, lb;

      fork
         forever begin
            @(negedge clk);
            if (a_rd_en || b_rd_en) begin
               chk("rd_exclusive", int'(a_rd_en && b_rd_en), 0);
               if (a_rd_en) begin
                  a_pulses++;
                  chk("rd_a_grant", int'(grant), 1);
                  chk("rd_a_nonempty", int'(wr_a > rd_a), 1);
               end
               if (b_rd_en) begin
                  b_pulses++;
                  chk("rd_b_grant", int'(grant), 2);
                  chk("rd_b_nonempty", int'(wr_b > rd_b), 1);
               end
            end
            if (tx_start) begin
               tx_seen++;
               chk("tx_start_busy", int'(tx_busy), 0);
               chk("tx_expected", int'(expq.size() > 0), 1);
               if (expq.size() > 0) begin
                  mon_e = expq.pop_front();
                  chk("tx_data", int'(tx_DATA), int'(mon_e.d));
                  chk("tx_grant", int'(grant), int'({mon_e.ch, ~mon_e.ch}));
                  chk("tx_busy_out", int'(busy), 1);
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single channel burst of three bytes
      load(1'b0, 8'h18); load(1'b0, 8'h29); load(1'b0, 8'h3A);
      predict_all();
      a0 = a_pulses; base = tx_seen;
      en = 1'b1;
      wait_drain("s1_drain");
      chk("s1_tx_count", tx_seen - base, 5);
      chk("s1_a_pulses", a_pulses - a0, 3);
      chk("s1_idle_busy", int'(busy), 0);
      chk("s1_idle_grant", int'(grant), 0);
      en = 1'b0;

      // Tie straight out of reset goes to channel A first
      do_reset("s2_rst");
      load(1'b0, 8'h11); load(1'b1, 8'h22);
      predict_all();
      base = tx_seen;
      en = 1'b1;
      wait_drain("s2_drain");
      chk("s2_tx_count", tx_seen - base, 6);
      en = 1'b0;

      // Six bytes split into bursts of BM and the remainder
      for (int i = 0; i < 6; i++) load(1'b0, 8'($urandom));
      predict_all();
      base = tx_seen;
      en = 1'b1;
      wait_drain("s3_drain");
      chk("s3_tx_count", tx_seen - base, 10);
      en = 1'b0;

      // en dropped during the second data byte
      for (int i = 0; i < 3; i++) begin
         load(1'b0, 8'($urandom));
         load(1'b1, 8'($urandom));
      end
      predict_burst();
      base = tx_seen;
      en = 1'b1;
      wait_tx(base + 3, "s4_wait_d2");
      en = 1'b0;
      wait_drain("s4_drain");
      repeat (40) @(negedge clk);
      chk("s4_no_new_hdr", tx_seen - base, 5);
      chk("s4_idle_busy", int'(busy), 0);
      predict_all();
      en = 1'b1;
      wait_drain("s4_resume");
      en = 1'b0;

      // Reset during TXW after the first data byte
      load(1'b0, 8'h5A); load(1'b0, 8'h6B); load(1'b0, 8'h7C);
      predict_all();
      base = tx_seen;
      en = 1'b1;
      wait_tx(base + 2, "s5_wait_d1");
      repeat (2) @(negedge clk);
      do_reset("s5_rst");
      predict_all();
      base = tx_seen;
      wait_drain("s5_drain");
      chk("s5_tx_count", tx_seen - base, 4);
      en = 1'b0;

      // Transmitter held busy after the header
      load(1'b0, 8'($urandom)); load(1'b0, 8'($urandom));
      predict_all();
      base = tx_seen;
      en = 1'b1;
      wait_tx(base + 1, "s6_wait_hdr");
      hold = 1'b1;
      r0 = a_pulses + b_pulses;
      t0 = tx_seen;
      repeat (50) @(negedge clk);
      chk("s6_hold_tx", tx_seen - t0, 0);
      chk("s6_hold_rd", a_pulses + b_pulses - r0, 0);
      hold = 1'b0;
      wait_drain("s6_drain");
      chk("s6_tx_count", tx_seen - base, 4);
      en = 1'b0;

      // Other channel filled mid-burst is served next
      load(1'b0, 8'($urandom)); load(1'b0, 8'($urandom)); load(1'b0, 8'($urandom));
      predict_all();
      en = 1'b1;
      base = tx_seen;
      wait_tx(base + 1, "s7_wait_hdr");
      load(1'b1, 8'($urandom)); load(1'b1, 8'($urandom));
      predict_all();
      wait_drain("s7_drain");
      chk("s7_tx_count", tx_seen - base, 9);
      en = 1'b0;

      // Randomized fills on both channels
      for (int r = 0; r < 8; r++) begin
         la = int'($urandom_range(0, 9));
         lb = int'($urandom_range(0, 9));
         if (la == 0 && lb == 0) la = 1;
         for (int i = 0; i < la; i++) load(1'b0, 8'($urandom));
         for (int i = 0; i < lb; i++) load(1'b1, 8'($urandom));
         predict_all();
         en = 1'b1;
         wait_drain("rand_drain");
         en = 1'b0;
         @(negedge clk);
      end
      chk("final_busy", int'(busy), 0);
      chk("final_grant", int'(grant), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
